// File: rtl/ui_pkg.sv
// Shared UI definitions: button bit positions and the per-button channel state.
package ui_pkg;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_M = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

endpackage

// File: rtl/push_input_conditioner_if.sv
// Button bundle between the board pins and the service modules.
// The release pulse is called release_evt because "release" is a reserved word.
interface push_input_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] push;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_evt;
    logic [N_BTN-1:0] repeating;

    modport master (output push, input level, press, release_evt, repeating);
    modport slave  (input push, output level, press, release_evt, repeating);
endinterface

// File: rtl/btn_channel.sv
// One button: two-flop synchronizer, debounce counter, IDLE/HELD/REPEAT FSM
// with a saturating hold timer. Every output is a flop.
module btn_channel
    import ui_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 1_000_000,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter bit          REPEAT_EN     = 1'b0
) (
    input  logic clk_osc,
    input  logic reset,
    input  logic push,
    output logic level,
    output logic press,
    output logic release_evt,
    output logic repeating
);
    localparam int unsigned DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HT_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [HT_W-1:0] RD_LAST = HT_W'(REPEAT_DELAY - 1);
    localparam logic [HT_W-1:0] RP_LAST = HT_W'(REPEAT_PERIOD - 1);
    localparam logic [HT_W-1:0] HT_SAT  = '1;

    logic            sync_p0, sync_p1;
    logic [DB_W-1:0] db_cnt;
    logic [HT_W-1:0] hold_cnt;
    btn_state_t      state;
    logic            accept, rise, fall;

    assign accept = (sync_p1 != level) && (db_cnt == DB_LAST);
    assign rise   = accept && !level;
    assign fall   = accept && level;

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            db_cnt      <= '0;
            level       <= 1'b0;
            hold_cnt    <= '0;
            state       <= IDLE;
            press       <= 1'b0;
            release_evt <= 1'b0;
            repeating   <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability filter
            sync_p0 <= push;
            sync_p1 <= sync_p0;

            // debounce: any agreement with level restarts the stability window
            if (sync_p1 == level || accept)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + 1'b1;
            if (accept)
                level <= !level;

            press       <= 1'b0;
            release_evt <= 1'b0;

            // an accepted fall is tested first so it beats a same-cycle repeat fire
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HELD;
                        press    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state       <= IDLE;
                        release_evt <= 1'b1;
                    end else if (REPEAT_EN && hold_cnt == RD_LAST) begin
                        state     <= REPEAT;
                        press     <= 1'b1;
                        repeating <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (hold_cnt != HT_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state       <= IDLE;
                        release_evt <= 1'b1;
                        repeating   <= 1'b0;
                    end else if (hold_cnt == RP_LAST) begin
                        press    <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    repeating <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/push_input_conditioner.sv
// Raw push buttons to clean synchronous level/press/release/repeat events.
// Wiring only: one independent btn_channel per button.
module push_input_conditioner
    import ui_pkg::*;
#(
    parameter int unsigned      N_BTN         = 5,
    parameter int unsigned      DB_CYCLES     = 1_000_000,
    parameter int unsigned      REPEAT_DELAY  = 50_000_000,
    parameter int unsigned      REPEAT_PERIOD = 10_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = 5'b00011
) (
    input logic                     clk_osc,
    input logic                     reset,
    push_input_conditioner_if.slave btn
);
    logic [N_BTN-1:0] level_w, press_w, release_w, repeating_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_ch (
            .clk_osc    (clk_osc),
            .reset      (reset),
            .push       (btn.push[i]),
            .level      (level_w[i]),
            .press      (press_w[i]),
            .release_evt(release_w[i]),
            .repeating  (repeating_w[i])
        );
    end

    assign btn.level       = level_w;
    assign btn.press       = press_w;
    assign btn.release_evt = release_w;
    assign btn.repeating   = repeating_w;

endmodule
